// File: rtl/display_scan_controller_if.sv
// Signal bundle between the scan controller and its driver/consumer.
// tick is a one-cycle strobe; outputs are register decodes and valid every cycle.
interface display_scan_controller_if #(
    parameter int N_DIG = 6
);
    localparam int IW = $clog2(N_DIG);

    logic                 tick;
    logic [N_DIG*5-1:0]   i_digits;
    logic                 i_lzb;
    logic                 i_freeze;
    logic [N_DIG-1:0]     o_an;
    logic [4:0]           o_digit;
    logic [IW-1:0]        o_idx;
    logic                 o_frame_start;
    logic                 dbg_on;

    modport master (
        output tick, i_digits, i_lzb, i_freeze,
        input  o_an, o_digit, o_idx, o_frame_start, dbg_on
    );

    modport slave (
        input  tick, i_digits, i_lzb, i_freeze,
        output o_an, o_digit, o_idx, o_frame_start, dbg_on
    );
endinterface

// File: rtl/display_scan_controller.sv
// Time-multiplexed seven-segment scan sequencer with dead-time blanking,
// per-frame digit snapshot and optional leading-zero blanking.
module display_scan_controller #(
    parameter int N_DIG       = 6,
    parameter int ON_TICKS    = 2,
    parameter int BLANK_TICKS = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    display_scan_controller_if.slave   bus
);
    localparam int IW   = $clog2(N_DIG);
    localparam int MAXT = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
    localparam int CW   = (MAXT < 2) ? 1 : $clog2(MAXT);

    localparam logic [CW-1:0] ON_LAST    = CW'(ON_TICKS - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIG - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [N_DIG*5-1:0]   snap;
    logic                 frame_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_BLANK;
            cnt         <= '0;
            idx         <= IDX_LAST;
            snap        <= '0;
            frame_start <= 1'b0;
        end else if (bus.tick) begin
            frame_start <= 1'b0;
            case (state)
                ST_ON: begin
                    if (cnt == ON_LAST) begin
                        state <= ST_BLANK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == BLANK_LAST) begin
                        state <= ST_ON;
                        cnt   <= '0;
                        // Wrapping back to digit 0 is the only point the digit bus is sampled.
                        if (idx == IDX_LAST) begin
                            idx         <= '0;
                            frame_start <= 1'b1;
                            if (!bus.i_freeze) begin
                                snap <= bus.i_digits;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end else begin
            frame_start <= 1'b0;
        end
    end

    logic [4:0]       digit_sel;
    logic             suppress;
    logic             upper_zero;
    logic [N_DIG-1:0] an;

    // upper_zero accumulates from the MSB down, so at word k it covers words k..N_DIG-1.
    always_comb begin
        digit_sel  = 5'd0;
        suppress   = 1'b0;
        upper_zero = 1'b1;
        for (int k = N_DIG - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (snap[5*k +: 5] == 5'd0);
            if (IW'(k) == idx) begin
                digit_sel = snap[5*k +: 5];
                if (k != 0) begin
                    suppress = bus.i_lzb && upper_zero;
                end
            end
        end
    end

    always_comb begin
        an = '1;
        if (state == ST_ON && !suppress) begin
            for (int k = 0; k < N_DIG; k++) begin
                if (IW'(k) == idx) begin
                    an[k] = 1'b0;
                end
            end
        end
    end

    assign bus.o_an          = an;
    assign bus.o_digit       = digit_sel;
    assign bus.o_idx         = idx;
    assign bus.o_frame_start = frame_start;
    assign bus.dbg_on        = (state == ST_ON);
endmodule
